// File: rtl/nn_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// nn_feeder : buffers host-loaded weight/sample words and streams one training
//             sample at a time into the NN core, returning its result.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module nn_feeder #(
  parameter int DW      = 32,
  parameter int N_D     = 4,
  parameter int N_W1    = 12,
  parameter int N_W2    = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [1:0]    host_sel,
  input  logic [DW-1:0] host_data,
  output logic          in_valid_d,
  output logic          in_valid_t,
  output logic          in_valid_w1,
  output logic          in_valid_w2,
  output logic [DW-1:0] data_point,
  output logic [DW-1:0] target,
  output logic [DW-1:0] weight1,
  output logic [DW-1:0] weight2,
  input  logic          nn_out_valid,
  input  logic [DW-1:0] nn_out,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic [15:0]   res_idx,
  output logic          busy,
  output logic          err_timeout,
  output logic          err_spur
);

  localparam int L_MAX = (N_W1 > N_D) ? N_W1 : N_D;
  localparam int KW    = $clog2(L_MAX + 1);
  localparam int W1CW  = $clog2(N_W1 + 1);
  localparam int W2CW  = $clog2(N_W2 + 1);
  localparam int DCW   = $clog2(N_D + 1);
  localparam int W1IW  = (N_W1 > 1) ? $clog2(N_W1) : 1;
  localparam int W2IW  = (N_W2 > 1) ? $clog2(N_W2) : 1;
  localparam int DIW   = (N_D > 1) ? $clog2(N_D) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [1:0] SEL_W1 = 2'd0;
  localparam logic [1:0] SEL_W2 = 2'd1;
  localparam logic [1:0] SEL_D  = 2'd2;

  localparam logic [KW-1:0]   K_ND      = KW'(N_D);
  localparam logic [KW-1:0]   K_NW1     = KW'(N_W1);
  localparam logic [KW-1:0]   K_NW2     = KW'(N_W2);
  localparam logic [KW-1:0]   K_D_LAST  = KW'(N_D - 1);
  localparam logic [KW-1:0]   K_W1_LAST = KW'(N_W1 - 1);
  localparam logic [TW-1:0]   T_LAST    = TW'(TIMEOUT - 1);
  localparam logic [W1CW-1:0] W1_FULL   = W1CW'(N_W1);
  localparam logic [W2CW-1:0] W2_FULL   = W2CW'(N_W2);
  localparam logic [DCW-1:0]  D_FULL    = DCW'(N_D);

  logic [DW-1:0]   w1_q [N_W1];
  logic [DW-1:0]   w2_q [N_W2];
  logic [DW-1:0]   d_q  [N_D];
  logic [DW-1:0]   t_q;
  logic [W1CW-1:0] w1_cnt_q;
  logic [W2CW-1:0] w2_cnt_q;
  logic [DCW-1:0]  d_cnt_q;
  logic            t_cnt_q;
  logic            weight_valid_q, weight_pending_q;

  logic [1:0]      state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            send_w_q, send_w_d;
  logic [TW-1:0]   wcnt_q;
  logic            idx_inc_q;

  logic            vd_q, vt_q, vw1_q, vw2_q;
  logic            vd_d, vt_d, vw1_d, vw2_d;
  logic [DW-1:0]   dp_q, tg_q, wo1_q, wo2_q;
  logic [DW-1:0]   dp_d, tg_d, wo1_d, wo2_d;
  logic            res_valid_q, err_timeout_q, err_spur_q;
  logic [DW-1:0]   res_data_q;
  logic [15:0]     res_idx_q;

  logic w1_full, w2_full, d_full, t_full;
  logic weights_done, sample_done, accept, issue_end, wait_exit, issuing;

  assign w1_full      = (w1_cnt_q == W1_FULL);
  assign w2_full      = (w2_cnt_q == W2_FULL);
  assign d_full       = (d_cnt_q == D_FULL);
  assign t_full       = t_cnt_q;
  assign weights_done = w1_full && w2_full;
  assign sample_done  = d_full && t_full;
  assign accept       = host_valid && host_ready;
  assign issue_end    = (state_q == S_ISSUE) && (state_d == S_WAIT);
  assign wait_exit    = (state_q == S_WAIT) && (state_d == S_IDLE);
  assign issuing      = (state_d == S_ISSUE);

  // Weight banks are frozen while a reload is queued or being streamed out.
  always_comb begin
    host_ready = 1'b0;
    case (host_sel)
      SEL_W1, SEL_W2: host_ready = !(weight_pending_q || ((state_q == S_ISSUE) && send_w_q));
      SEL_D:          host_ready = !d_full;
      default:        host_ready = !t_full;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    send_w_d = send_w_q;
    case (state_q)
      S_IDLE: begin
        if (sample_done && weight_valid_q) begin
          state_d  = S_ISSUE;
          k_d      = '0;
          send_w_d = weight_pending_q;
        end
      end
      S_ISSUE: begin
        if (k_q == (send_w_q ? K_W1_LAST : K_D_LAST)) state_d = S_WAIT;
        else                                          k_d     = k_q + KW'(1);
      end
      S_WAIT: begin
        if (nn_out_valid || (wcnt_q == T_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next-state index so they line up with ISSUE.
  always_comb begin
    vd_d  = issuing && (k_d < K_ND);
    vt_d  = issuing && (k_d == '0);
    vw1_d = issuing && send_w_d && (k_d < K_NW1);
    vw2_d = issuing && send_w_d && (k_d < K_NW2);
    dp_d  = vd_d  ? d_q[k_d[DIW-1:0]]   : '0;
    tg_d  = vt_d  ? t_q                 : '0;
    wo1_d = vw1_d ? w1_q[k_d[W1IW-1:0]] : '0;
    wo2_d = vw2_d ? w2_q[k_d[W2IW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (host_sel)
        SEL_W1:  if (!w1_full) w1_q[w1_cnt_q[W1IW-1:0]] <= host_data;
        SEL_W2:  if (!w2_full) w2_q[w2_cnt_q[W2IW-1:0]] <= host_data;
        SEL_D:   if (!d_full)  d_q[d_cnt_q[DIW-1:0]]    <= host_data;
        default: if (!t_full)  t_q                      <= host_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      k_q              <= '0;
      send_w_q         <= 1'b0;
      wcnt_q           <= '0;
      idx_inc_q        <= 1'b0;
      w1_cnt_q         <= '0;
      w2_cnt_q         <= '0;
      d_cnt_q          <= '0;
      t_cnt_q          <= 1'b0;
      weight_valid_q   <= 1'b0;
      weight_pending_q <= 1'b0;
      vd_q             <= 1'b0;
      vt_q             <= 1'b0;
      vw1_q            <= 1'b0;
      vw2_q            <= 1'b0;
      dp_q             <= '0;
      tg_q             <= '0;
      wo1_q            <= '0;
      wo2_q            <= '0;
      res_valid_q      <= 1'b0;
      res_data_q       <= '0;
      res_idx_q        <= '0;
      err_timeout_q    <= 1'b0;
      err_spur_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      send_w_q <= send_w_d;
      vd_q     <= vd_d;
      vt_q     <= vt_d;
      vw1_q    <= vw1_d;
      vw2_q    <= vw2_d;
      dp_q     <= dp_d;
      tg_q     <= tg_d;
      wo1_q    <= wo1_d;
      wo2_q    <= wo2_d;

      if (accept) begin
        case (host_sel)
          SEL_W1:  if (!w1_full) w1_cnt_q <= w1_cnt_q + W1CW'(1);
          SEL_W2:  if (!w2_full) w2_cnt_q <= w2_cnt_q + W2CW'(1);
          SEL_D:   if (!d_full)  d_cnt_q  <= d_cnt_q + DCW'(1);
          default: if (!t_full)  t_cnt_q  <= 1'b1;
        endcase
      end
      if (issue_end) begin
        d_cnt_q <= '0;
        t_cnt_q <= 1'b0;
        if (send_w_q) weight_pending_q <= 1'b0;
      end
      if (weights_done) begin
        w1_cnt_q         <= '0;
        w2_cnt_q         <= '0;
        weight_valid_q   <= 1'b1;
        weight_pending_q <= 1'b1;
      end

      wcnt_q      <= (state_q == S_WAIT) ? wcnt_q + TW'(1) : '0;
      res_valid_q <= (state_q == S_WAIT) && nn_out_valid;
      if ((state_q == S_WAIT) && nn_out_valid) res_data_q <= nn_out;
      // Index advances one cycle late so res_idx tags the strobed result.
      idx_inc_q <= wait_exit;
      if (idx_inc_q) res_idx_q <= res_idx_q + 16'd1;
      if ((state_q == S_WAIT) && !nn_out_valid && (wcnt_q == T_LAST)) err_timeout_q <= 1'b1;
      if (nn_out_valid && (state_q != S_WAIT)) err_spur_q <= 1'b1;
    end
  end

  assign in_valid_d  = vd_q;
  assign in_valid_t  = vt_q;
  assign in_valid_w1 = vw1_q;
  assign in_valid_w2 = vw2_q;
  assign data_point  = dp_q;
  assign target      = tg_q;
  assign weight1     = wo1_q;
  assign weight2     = wo2_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_idx     = res_idx_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_timeout_q;
  assign err_spur    = err_spur_q;

endmodule
`default_nettype wire
